// File: rtl/hex_char_uart_tx.sv
// Converts a handshaked 4-bit nibble to its ASCII hex digit and sends it as a UART 8N1 frame.
// Define HEX_NEWLINE_EN to append CR/LF frames after every eighth character.
module hex_char_uart_tx #(
  parameter int unsigned CLKS_PER_BIT  = 434,
  parameter int unsigned UPPERCASE_HEX = 1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       go,
  input  logic [3:0] character,
  output logic       character_done,
  output logic       tx,
  output logic       busy
);

  localparam int unsigned BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

`ifdef HEX_NEWLINE_EN
  // CR and LF are the start-bit phases of the two newline frames
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, DONE, CR, LF} state_t;
  localparam logic [1:0] FR_CHAR = 2'd0;
  localparam logic [1:0] FR_CR   = 2'd1;
  localparam logic [1:0] FR_LF   = 2'd2;
  logic [1:0] frame_q, frame_d;
  logic [2:0] line_q, line_d;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, DONE} state_t;
`endif

  state_t            state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d, baud_inc;
  logic [2:0]        bit_q, bit_d;
  logic [3:0]        nib_q, nib_d;
  logic [7:0]        byte_d;
  logic              tick, start_d, tx_d, done_d, busy_d;

  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    logic [7:0] base;
    if (n < 4'd10)               base = 8'h30;
    else if (UPPERCASE_HEX != 0) base = 8'h37;
    else                         base = 8'h57;
    return base + {4'h0, n};
  endfunction

  // state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // next state, counters and next output values
  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    nib_d    = nib_q;
`ifdef HEX_NEWLINE_EN
    frame_d  = frame_q;
    line_d   = line_q;
`endif
    tick     = (baud_q == BAUD_LAST);
    baud_inc = baud_q + BAUD_W'(1);

    case (state_q)
      IDLE: begin
        if (go) begin
          nib_d   = character;
          baud_d  = '0;
          state_d = START;
        end
      end
`ifdef HEX_NEWLINE_EN
      START, CR, LF: begin
`else
      START: begin
`endif
        if (tick) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = DATA;
        end else begin
          baud_d = baud_inc;
        end
      end
      DATA: begin
        if (tick) begin
          baud_d = '0;
          if (bit_q == 3'd7) state_d = STOP;
          else               bit_d   = bit_q + 3'd1;
        end else begin
          baud_d = baud_inc;
        end
      end
      STOP: begin
        if (tick) begin
          baud_d  = '0;
          state_d = DONE;
`ifdef HEX_NEWLINE_EN
          if (frame_q == FR_CHAR) begin
            line_d = line_q + 3'd1;
            if (line_q == 3'd7) begin
              frame_d = FR_CR;
              state_d = CR;
            end
          end else if (frame_q == FR_CR) begin
            frame_d = FR_LF;
            state_d = LF;
          end
`endif
        end else begin
          baud_d = baud_inc;
        end
      end
      DONE: begin
        if (!go) begin
          state_d = IDLE;
`ifdef HEX_NEWLINE_EN
          frame_d = FR_CHAR;
`endif
        end
      end
      default: state_d = IDLE;
    endcase

    byte_d = hex_ascii(nib_d);
`ifdef HEX_NEWLINE_EN
    if (frame_d == FR_CR)      byte_d = 8'h0D;
    else if (frame_d == FR_LF) byte_d = 8'h0A;
    start_d = (state_d == START) || (state_d == CR) || (state_d == LF);
`else
    start_d = (state_d == START);
`endif

    tx_d = 1'b1;
    if (start_d)               tx_d = 1'b0;
    else if (state_d == DATA)  tx_d = byte_d[bit_d];
    done_d = (state_d == DONE);
    busy_d = (state_d != IDLE);
  end

  // datapath and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      baud_q         <= '0;
      bit_q          <= '0;
      nib_q          <= '0;
      tx             <= 1'b1;
      character_done <= 1'b0;
      busy           <= 1'b0;
`ifdef HEX_NEWLINE_EN
      frame_q        <= FR_CHAR;
      line_q         <= '0;
`endif
    end else begin
      baud_q         <= baud_d;
      bit_q          <= bit_d;
      nib_q          <= nib_d;
      tx             <= tx_d;
      character_done <= done_d;
      busy           <= busy_d;
`ifdef HEX_NEWLINE_EN
      frame_q        <= frame_d;
      line_q         <= line_d;
`endif
    end
  end

endmodule

// File: tb/tb_hex_char_uart_tx.sv
// Bench for hex_char_uart_tx: uppercase and lowercase instances share stimulus;
// frames are sampled mid-bit and compared with bytes derived from hex digit strings.
module tb_hex_char_uart_tx;

  localparam int CPB   = 4;
  localparam int FRAME = 10 * CPB;
`ifdef HEX_NEWLINE_EN
  localparam bit NL = 1'b1;
`else
  localparam bit NL = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       go = 1'b0;
  logic [3:0] character = 4'h0;
  logic       done_u, tx_u, busy_u;
  logic       done_l, tx_l, busy_l;

  always #5 clk = ~clk;

  hex_char_uart_tx #(.CLKS_PER_BIT(CPB), .UPPERCASE_HEX(1)) dut_u (
    .clk(clk), .reset_n(reset_n), .go(go), .character(character),
    .character_done(done_u), .tx(tx_u), .busy(busy_u));

  hex_char_uart_tx #(.CLKS_PER_BIT(CPB), .UPPERCASE_HEX(0)) dut_l (
    .clk(clk), .reset_n(reset_n), .go(go), .character(character),
    .character_done(done_l), .tx(tx_l), .busy(busy_l));

  int n_checks = 0;
  int n_pass   = 0;
  int line_model = 0;

  typedef struct {
    logic [3:0] c;
    int         hold;
    logic [7:0] eu;
    logic [7:0] el;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic logic [31:0] frame_bit(input logic [7:0] b, input int k);
    if (k == 0) return 32'd0;
    if (k == 9) return 32'd1;
    return {31'd0, b[k-1]};
  endfunction

  // One character: go raised now (caller sits at a negedge), dropped at negedge hold-1 after accept
  task automatic run_char(input logic [3:0] c, input int hold,
                          input logic [7:0] exp_u, input logic [7:0] exp_l, input string tag);
    logic [7:0] bu[3];
    logic [7:0] bl[3];
    int nfr, total, d, release_n, f, k;
    bit stay_ok;
    bu[0] = exp_u; bu[1] = 8'h0D; bu[2] = 8'h0A;
    bl[0] = exp_l; bl[1] = 8'h0D; bl[2] = 8'h0A;
    nfr = (NL && line_model == 7) ? 3 : 1;
    line_model = (line_model + 1) % 8;
    total = nfr * FRAME;
    d = hold - 1;
    release_n = ((total > d) ? total : d) + 1;
    stay_ok = 1'b1;
    character = c;
    go = 1'b1;
    @(posedge clk);
    for (int n = 0; n <= release_n; n++) begin
      @(negedge clk);
      if (n < total) begin
        if (n % CPB == 1) begin
          f = n / FRAME;
          k = (n % FRAME) / CPB;
          check($sformatf("%s upper frame%0d bit%0d", tag, f, k), {31'd0, tx_u}, frame_bit(bu[f], k));
          check($sformatf("%s lower frame%0d bit%0d", tag, f, k), {31'd0, tx_l}, frame_bit(bl[f], k));
        end
        if (n == 0) check($sformatf("%s busy after accept", tag), {31'd0, busy_u}, 32'd1);
        if (n == 5) character = 4'($urandom);
        if (n == total - 1) check($sformatf("%s done early", tag), {31'd0, done_u}, 32'd0);
      end else if (n == total) begin
        check($sformatf("%s done rise upper", tag), {31'd0, done_u}, 32'd1);
        check($sformatf("%s done rise lower", tag), {31'd0, done_l}, 32'd1);
      end else if (n < release_n) begin
        if (tx_u !== 1'b1 || done_u !== 1'b1 || busy_u !== 1'b1) stay_ok = 1'b0;
      end else begin
        check($sformatf("%s held in DONE", tag), {31'd0, stay_ok}, 32'd1);
        check($sformatf("%s done fall", tag), {31'd0, done_u}, 32'd0);
        check($sformatf("%s busy fall", tag), {31'd0, busy_u}, 32'd0);
        check($sformatf("%s done fall lower", tag), {31'd0, done_l}, 32'd0);
      end
      if (n == d) go = 1'b0;
    end
  endtask

  initial begin
    vec_t  tbl[12];
    string hu = "0123456789ABCDEF";
    string hl = "0123456789abcdef";
    logic [3:0] rc;
    int rh;

    // DEADBEEF nibbles LSB first, then handshake and single-character cases
    tbl[0]  = '{4'hF, 1,   8'h46, 8'h66};
    tbl[1]  = '{4'hE, 30,  8'h45, 8'h65};
    tbl[2]  = '{4'hE, 1,   8'h45, 8'h65};
    tbl[3]  = '{4'hB, 45,  8'h42, 8'h62};
    tbl[4]  = '{4'hD, 1,   8'h44, 8'h64};
    tbl[5]  = '{4'hA, 41,  8'h41, 8'h61};
    tbl[6]  = '{4'hE, 2,   8'h45, 8'h65};
    tbl[7]  = '{4'hD, 1,   8'h44, 8'h64};
    tbl[8]  = '{4'h7, 100, 8'h37, 8'h37};
    tbl[9]  = '{4'hC, 1,   8'h43, 8'h63};
    tbl[10] = '{4'h0, 1,   8'h30, 8'h30};
    tbl[11] = '{4'h7, 1,   8'h37, 8'h37};

    repeat (3) @(negedge clk);
    check("reset tx", {31'd0, tx_u}, 32'd1);
    check("reset done", {31'd0, done_u}, 32'd0);
    check("reset busy", {31'd0, busy_u}, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // reset mid-DATA while a zero data bit is on the line
    character = 4'h7;
    go = 1'b1;
    @(posedge clk);
    for (int n = 0; n <= 17; n++) @(negedge clk);
    check("pre-reset data bit", {31'd0, tx_u}, 32'd0);
    go = 1'b0;
    reset_n = 1'b0;
    #1;
    check("mid-frame reset tx", {31'd0, tx_u}, 32'd1);
    check("mid-frame reset busy", {31'd0, busy_u}, 32'd0);
    check("mid-frame reset done", {31'd0, done_u}, 32'd0);
    check("mid-frame reset tx lower", {31'd0, tx_l}, 32'd1);
    @(negedge clk);
    reset_n = 1'b1;
    line_model = 0;
    @(negedge clk);

    for (int i = 0; i < 12; i++)
      run_char(tbl[i].c, tbl[i].hold, tbl[i].eu, tbl[i].el, $sformatf("vec%0d", i));

    for (int i = 0; i < 20; i++) begin
      rc = 4'($urandom);
      rh = int'($urandom_range(1, 50));
      run_char(rc, rh, 8'(hu[int'(rc)]), 8'(hl[int'(rc)]), $sformatf("rnd%0d", i));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
